heichips25_pin_responder: RTL and testbench
===========================================

Name: heichips25_pin_responder

Overview:
- Tiny-wrapper-compatible project that acts as the device end of a byte-wide, four-phase req/ack host protocol on the standard project pins.
- The host drives `ui_in` and a request line; the block decodes commands and serves a 16x8 register file, acknowledging each transfer.
- Sits beside the other projects under the tiny wrapper and is selected by `ena`.
- Its host-side counterpart is the bench, or a future on-chip driver.

Parameters:
- SYNC_STAGES, 2, flops in the req synchronizer (min 2).
- TIMEOUT_CYCLES, 255, cycles allowed in WAIT_DATA before abort (1..255).

Ports:
- clk  input  1  project clock.
- rst_n  input  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low.
- ena  input  1  project enable from wrapper.
- ui_in  input  8  host command/data byte.
- uio_in  input  8  bit0 = req from host; other bits ignored.
- uo_out  output  8  response byte.
- uio_out  output  8  bit1 ack, bit2 err (sticky), bits4:3 FSM state code, bits7:5 and bit0 = 0.
- uio_oe  output  8  constant 8'b0001_1110.

Behaviour:
- Reset (async, rst_n=0):
  - uo_out=0, uio_out=0, all registers=0, transaction counter=0, err=0, timeout counter=0, FSM=IDLE.
  - The synchronizer is cleared.
- req synchronization and acceptance:
  - uio_in[0] passes through SYNC_STAGES flops; req_s is the last stage.
  - A transfer is accepted in the cycle req_s is 1 while in IDLE or WAIT_DATA.
  - ui_in is sampled in that same cycle; the host holds ui_in stable until it sees ack.
- Command byte: op = ui_in[7:6], addr = ui_in[5:2], ui_in[1:0] ignored.
- FSM states and codes:
  - IDLE (00):
    - On req_s=1, latch the command and execute per op.
    - ack<=1 on the next edge; go to ACK_CMD (01).
  - ACK_CMD (01):
    - Hold ack=1 until req_s=0, then ack<=0.
    - Go to WAIT_DATA if op=WRITE, else IDLE.
    - Non-WRITE ops increment the counter here.
  - WAIT_DATA (10):
    - On req_s=1: reg[addr]<=ui_in, uo_out<=ui_in, ack<=1, clear the timeout counter, go to ACK_DATA.
    - Each cycle without req increments the timeout counter.
    - On reaching TIMEOUT_CYCLES: err<=1, go to IDLE, no register write, no counter increment.
  - ACK_DATA (11): hold ack until req_s=0, then ack<=0, counter+1, go to IDLE.
- Ops:
  - 00 WRITE: two-phase; the data byte is the second transfer. uo_out unchanged at command time.
  - 01 READ: uo_out<=reg[addr].
  - 10 INC: reg[addr]<=reg[addr]+1, mod 256 (0xFF→0x00); uo_out<=the new value.
  - 11 STATUS: uo_out<=transaction counter (8-bit, wraps 0xFF→0x00). Clears err on the same edge.
- Timing:
  - Latency from a uio_in[0] rise to ack rise is SYNC_STAGES+1 clocks.
  - uo_out is valid no later than the ack rise and holds until the next executed op.
  - Ack falls 1 clock after req_s falls.
- ena=0:
  - FSM, timeout counter, registers and counter are frozen; outputs hold their values.
  - The synchronizer keeps sampling.
  - On re-enable, operation resumes from the held state.
- Simultaneous events:
  - Timeout expiry and req_s rise in the same cycle: the req wins, and the data is accepted.
  - STATUS clearing err while a timeout fires is impossible, because the two occur in different states.
- Mid-operation reset: everything returns to reset values immediately. A host still holding req sees ack=0.
  - If the host still holds req high after reset, the sync chain refills. In IDLE this is a new command and is executed; the host must drop req first.

Test Plan:
- WRITE addr5 (cmd 0x14), data 0xA7, then READ addr5 (cmd 0x54) → uo_out=0xA7 after the second ack; each ack rises 3 clocks after req; counter=2.
- reg3=0xFF via WRITE, then INC addr3 (cmd 0x8C) → uo_out=0x00, reg3=0x00; a further INC gives 0x01.
- WRITE cmd, then no data req for 255 cycles → FSM IDLE, uio_out[2]=1, target reg unchanged; STATUS (0xC0) → uo_out=counter value, err=0.
- 256 completed READs then STATUS → uo_out=0x00 (wrap; the STATUS itself counts after the response).
- rst_n pulsed low in WAIT_DATA → all outputs 0 asynchronously; uio_oe=0x1E throughout; registers read back 0x00.
- ena=0 while req is raised → no ack; ena=1 → ack 1 clock later, command executes once.

Source files
------------

// File: rtl/heichips25_pin_responder_if.sv
// heichips25_pin_responder_if: tiny-wrapper project pins between host and responder
interface heichips25_pin_responder_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
    modport slave (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/heichips25_pin_responder.sv
// heichips25_pin_responder: four-phase req/ack device serving a 16x8 register file
module heichips25_pin_responder #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic clk,
    input logic rst_n,
    heichips25_pin_responder_if.slave pins
);
    typedef enum logic [1:0] {IDLE = 2'b00, ACK_CMD = 2'b01, WAIT_DATA = 2'b10, ACK_DATA = 2'b11} state_t;
    localparam logic [1:0] OP_WRITE = 2'd0, OP_READ = 2'd1, OP_INC = 2'd2;
    logic [SYNC_STAGES-1:0] sync;
    logic req_s, ack, ack_n, err, err_n, wr_en, unused;
    state_t state, state_n;
    logic [1:0] op, op_n;
    logic [3:0] addr, addr_n, wr_addr;
    logic [7:0] uo, uo_n, cnt, cnt_n, tcnt, tcnt_n, wr_data, cur;
    logic [7:0] regs [16];
    assign req_s = sync[SYNC_STAGES-1];
    assign cur = regs[pins.ui_in[5:2]];
    assign pins.uo_out = uo;
    assign pins.uio_out = {3'b000, state, err, ack, 1'b0};
    assign pins.uio_oe = 8'b0001_1110;
    assign unused = ^pins.uio_in[7:1];
    always_comb begin
        state_n = state;
        ack_n = ack;
        err_n = err;
        op_n = op;
        addr_n = addr;
        uo_n = uo;
        cnt_n = cnt;
        tcnt_n = tcnt;
        wr_en = 1'b0;
        wr_addr = pins.ui_in[5:2];
        wr_data = cur + 8'd1;
        unique case (state)
            IDLE: if (req_s) begin
                op_n = pins.ui_in[7:6];
                addr_n = pins.ui_in[5:2];
                ack_n = 1'b1;
                state_n = ACK_CMD;
                wr_en = pins.ui_in[7:6] == OP_INC;
                uo_n = pins.ui_in[7:6] == OP_WRITE ? uo :
                       pins.ui_in[7:6] == OP_READ  ? cur :
                       pins.ui_in[7:6] == OP_INC   ? cur + 8'd1 : cnt;
                err_n = pins.ui_in[7:6] == 2'd3 ? 1'b0 : err;
            end
            ACK_CMD: if (!req_s) begin
                ack_n = 1'b0;
                tcnt_n = '0;
                state_n = op == OP_WRITE ? WAIT_DATA : IDLE;
                cnt_n = op == OP_WRITE ? cnt : cnt + 8'd1;
            end
            WAIT_DATA: if (req_s) begin
                wr_en = 1'b1;
                wr_addr = addr;
                wr_data = pins.ui_in;
                uo_n = pins.ui_in;
                ack_n = 1'b1;
                tcnt_n = '0;
                state_n = ACK_DATA;
            end else if (tcnt == 8'(TIMEOUT_CYCLES - 1)) begin
                // abandoned write: flag it and drop back without touching the target
                err_n = 1'b1;
                tcnt_n = '0;
                state_n = IDLE;
            end else begin
                tcnt_n = tcnt + 8'd1;
            end
            ACK_DATA: if (!req_s) begin
                ack_n = 1'b0;
                cnt_n = cnt + 8'd1;
                state_n = IDLE;
            end
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= '0;
        else sync <= {sync[SYNC_STAGES-2:0], pins.uio_in[0]};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ack <= 1'b0;
            err <= 1'b0;
            op <= '0;
            addr <= '0;
            uo <= '0;
            cnt <= '0;
            tcnt <= '0;
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else if (pins.ena) begin
            state <= state_n;
            ack <= ack_n;
            err <= err_n;
            op <= op_n;
            addr <= addr_n;
            uo <= uo_n;
            cnt <= cnt_n;
            tcnt <= tcnt_n;
            if (wr_en) regs[wr_addr] <= wr_data;
        end
    end
endmodule

// File: tb/tb_heichips25_pin_responder.sv
// tb_heichips25_pin_responder: host-side driver with a transaction-level model of the responder
module tb_heichips25_pin_responder;
    localparam int TO = 255;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    heichips25_pin_responder_if pins();
    heichips25_pin_responder #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst_n(rst_n), .pins(pins));
    int n_pass = 0;
    int n_tot = 0;
    logic [7:0] m_regs [16];
    logic [7:0] m_cnt, exp_uo;
    logic m_err;
    wire ack = pins.uio_out[1];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    endtask

    // Every cycle: fixed pins, and while ack is high the response must match the model
    always @(negedge clk) begin
        chk("uio_oe", pins.uio_oe, 8'h1E);
        chk("uio_out unused bits", {4'b0, pins.uio_out[7:5], pins.uio_out[0]}, 8'h00);
        if (rst_n && ack) begin
            chk("uo_out at ack", pins.uo_out, exp_uo);
            chk("err at ack", {7'b0, pins.uio_out[2]}, {7'b0, m_err});
            chk("state at ack", {7'b0, pins.uio_out[3]}, 8'h01);
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
        m_cnt = 8'h00;
        m_err = 1'b0;
        exp_uo = 8'h00;
    endtask

    task automatic wait_ack(input logic lvl, input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack !== lvl && n < 20);
        chk(name, 8'(n), 8'd3);
    endtask

    task automatic xfer(input logic [7:0] b);
        pins.ui_in = b;
        pins.uio_in = {7'($urandom), 1'b1};
        wait_ack(1'b1, "ack rise latency");
        pins.uio_in = {7'($urandom), 1'b0};
        wait_ack(1'b0, "ack fall latency");
    endtask

    task automatic do_op(input logic [1:0] op, input logic [3:0] a, input logic [7:0] d);
        logic [7:0] c;
        c = {op, a, 2'($urandom)};
        case (op)
            2'd0: begin xfer(c); exp_uo = d; xfer(d); m_regs[a] = d; end
            2'd1: begin exp_uo = m_regs[a]; xfer(c); end
            2'd2: begin m_regs[a] = m_regs[a] + 8'd1; exp_uo = m_regs[a]; xfer(c); end
            default: begin exp_uo = m_cnt; m_err = 1'b0; xfer(c); end
        endcase
        m_cnt = m_cnt + 8'd1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        pins.ena = 1'b1;
        pins.ui_in = 8'h00;
        pins.uio_in = 8'h00;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset uo_out", pins.uo_out, 8'h00);
        chk("reset uio_out", pins.uio_out, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);
        // write then read back, counter then reads 2
        do_op(2'd0, 4'd5, 8'hA7);
        do_op(2'd1, 4'd5, 8'h00);
        chk("read addr5", pins.uo_out, 8'hA7);
        do_op(2'd3, 4'd0, 8'h00);
        chk("status count", pins.uo_out, 8'h02);
        // increment wraps
        do_op(2'd0, 4'd3, 8'hFF);
        do_op(2'd2, 4'd3, 8'h00);
        chk("inc wrap", pins.uo_out, 8'h00);
        do_op(2'd2, 4'd3, 8'h00);
        chk("inc again", pins.uo_out, 8'h01);
        for (int i = 0; i < 60; i++)
            do_op(2'($urandom_range(0, 3)), 4'($urandom), 8'($urandom));
        // abandoned write times out exactly after TO idle cycles
        xfer({2'b00, 4'd7, 2'b00});
        repeat (TO - 1) @(negedge clk);
        chk("state before timeout", {6'b0, pins.uio_out[4:3]}, 8'h02);
        chk("err before timeout", {7'b0, pins.uio_out[2]}, 8'h00);
        @(negedge clk);
        chk("state after timeout", {6'b0, pins.uio_out[4:3]}, 8'h00);
        chk("err after timeout", {7'b0, pins.uio_out[2]}, 8'h01);
        m_err = 1'b1;
        do_op(2'd1, 4'd7, 8'h00);
        do_op(2'd3, 4'd0, 8'h00);
        chk("err cleared by status", {7'b0, pins.uio_out[2]}, 8'h00);
        // enable gating: req seen while disabled is served once on re-enable
        pins.ena = 1'b0;
        pins.ui_in = {2'b01, 4'd5, 2'b00};
        pins.uio_in = 8'h01;
        repeat (6) begin
            @(negedge clk);
            chk("no ack while disabled", {7'b0, ack}, 8'h00);
        end
        exp_uo = m_regs[5];
        pins.ena = 1'b1;
        @(negedge clk);
        chk("ack after enable", {7'b0, ack}, 8'h01);
        pins.uio_in = 8'h00;
        wait_ack(1'b0, "ack fall after enable");
        m_cnt = m_cnt + 8'd1;
        do_op(2'd3, 4'd0, 8'h00);
        // asynchronous reset while waiting for data
        xfer({2'b00, 4'd9, 2'b00});
        #2 rst_n = 1'b0;
        #1;
        chk("async reset uo_out", pins.uo_out, 8'h00);
        chk("async reset uio_out", pins.uio_out, 8'h00);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(2'd1, 4'd9, 8'h00);
        chk("reg after reset", pins.uo_out, 8'h00);
        // 256 completed reads wrap the counter
        for (int i = 0; i < 255; i++) do_op(2'd1, 4'($urandom), 8'h00);
        do_op(2'd3, 4'd0, 8'h00);
        chk("counter wrap", pins.uo_out, 8'h00);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
